// File: rtl/i2c_target_responder_if.sv
// I2C pin bundle between a bus master and the target responder.
// sda_o is the target's open-drain drive: 1 = released, 0 = pull low.
interface i2c_target_responder_if;
    logic scl_i;
    logic sda_i;
    logic sda_o;

    modport master (output scl_i, output sda_i, input sda_o);
    modport slave  (input scl_i, input sda_i, output sda_o);
endinterface

// File: rtl/i2c_target_responder.sv
// Oversampled I2C target with a preloadable register file, pointer auto-increment,
// repeated START support and read-side NACK reporting.
module i2c_target_responder #(
    parameter logic [6:0] TARGET_ADDR = 7'b0101011,
    parameter int         NUM_REGS    = 16,
    parameter int         PTR_W       = 4,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    i2c_target_responder_if.slave bus,
    input  logic                 cfg_we,
    input  logic [PTR_W-1:0]     cfg_addr,
    input  logic [7:0]           cfg_wdata,
    output logic                 busy,
    output logic                 rx_valid,
    output logic [PTR_W-1:0]     rx_ptr,
    output logic [7:0]           rx_data,
    output logic                 nack_seen,
    output logic [3:0]           state_dbg,
    output logic [PTR_W-1:0]     ptr_dbg
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8,
        WAIT_STOP = 4'd9
    } state_t;

    state_t              state, state_n;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                scl_s, sda_s, scl_d, sda_d;
    logic                scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]          cnt, cnt_n;
    logic [7:0]          shreg, shreg_n;
    logic [7:0]          byte_in;
    logic [PTR_W-1:0]    ptr, ptr_n;
    logic                sda_q, sda_n;
    logic                rx_valid_n, nack_n, wr_en;
    logic [PTR_W-1:0]    rx_ptr_n;
    logic [7:0]          rx_data_n;
    logic [7:0]          regs [NUM_REGS];

    // Synchronisers reset to the idle-bus level so reset release never fakes an edge.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign byte_in   = {shreg[6:0], sda_s};

    assign busy      = (state != IDLE);
    assign bus.sda_o = sda_q;
    assign state_dbg = state;
    assign ptr_dbg   = ptr;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            ptr       <= '0;
            sda_q     <= 1'b1;
            rx_valid  <= 1'b0;
            rx_ptr    <= '0;
            rx_data   <= '0;
            nack_seen <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            ptr       <= ptr_n;
            sda_q     <= sda_n;
            rx_valid  <= rx_valid_n;
            rx_ptr    <= rx_ptr_n;
            rx_data   <= rx_data_n;
            nack_seen <= nack_n;
        end
    end

    // Bus writes only occur while busy, so they never collide with a preload.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else if (wr_en) begin
            regs[ptr] <= byte_in;
        end else if (cfg_we && !busy) begin
            regs[cfg_addr] <= cfg_wdata;
        end
    end

    // ACK states use cnt==8 for "drive low at next fall" and cnt==9 for "9th clock seen".
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        shreg_n    = shreg;
        ptr_n      = ptr;
        sda_n      = sda_q;
        rx_valid_n = 1'b0;
        rx_ptr_n   = rx_ptr;
        rx_data_n  = rx_data;
        nack_n     = 1'b0;
        wr_en      = 1'b0;

        if (stop_det) begin
            state_n = IDLE;
            sda_n   = 1'b1;
        end else if (start_det) begin
            state_n = ADDR;
            cnt_n   = '0;
            sda_n   = 1'b1;
        end else begin
            case (state)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shreg_n = byte_in;
                        cnt_n   = cnt + 4'd1;
                        if (cnt == 4'd7)
                            state_n = (byte_in[7:1] == TARGET_ADDR) ? ADDR_ACK : WAIT_STOP;
                    end
                end
                PTR: begin
                    if (scl_rise) begin
                        shreg_n = byte_in;
                        cnt_n   = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            ptr_n   = byte_in[PTR_W-1:0];
                            state_n = PTR_ACK;
                        end
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        shreg_n = byte_in;
                        cnt_n   = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            wr_en      = 1'b1;
                            rx_valid_n = 1'b1;
                            rx_ptr_n   = ptr;
                            rx_data_n  = byte_in;
                            state_n    = WDATA_ACK;
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_rise) begin
                        cnt_n = 4'd9;
                    end else if (scl_fall) begin
                        if (cnt == 4'd9) begin
                            sda_n = 1'b1;
                            cnt_n = '0;
                            if (state == ADDR_ACK && shreg[0]) begin
                                shreg_n = regs[ptr];
                                sda_n   = regs[ptr][7];
                                state_n = RDATA;
                            end else if (state == ADDR_ACK) begin
                                state_n = PTR;
                            end else begin
                                if (state == WDATA_ACK) ptr_n = ptr + 1'b1;
                                state_n = WDATA;
                            end
                        end else begin
                            sda_n = 1'b0;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        shreg_n = {shreg[6:0], 1'b0};
                        cnt_n   = cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            sda_n   = 1'b1;
                            state_n = RDATA_ACK;
                        end else begin
                            sda_n = shreg[7];
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        ptr_n = ptr + 1'b1;
                        if (sda_s) begin
                            nack_n  = 1'b1;
                            state_n = WAIT_STOP;
                        end else begin
                            cnt_n = 4'd9;
                        end
                    end else if (scl_fall && cnt == 4'd9) begin
                        shreg_n = regs[ptr];
                        sda_n   = regs[ptr][7];
                        cnt_n   = '0;
                        state_n = RDATA;
                    end
                end
                WAIT_STOP: sda_n = 1'b1;
                default: begin
                    state_n = IDLE;
                    sda_n   = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bit-banged I2C master driving the target responder, with write and read scoreboards.
module tb_i2c_target_responder;

  localparam int PTR_W = 4;
  localparam logic [3:0] S_IDLE = 4'd0, S_ADDR_ACK = 4'd2, S_WAIT_STOP = 4'd9;

  logic PCLK = 1'b0;
  logic PRESET;
  logic cfg_we;
  logic [PTR_W-1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic busy, rx_valid, nack_seen;
  logic [PTR_W-1:0] rx_ptr, ptr_dbg;
  logic [7:0] rx_data;
  logic [3:0] state_dbg;

  i2c_target_responder_if bus_if();

  i2c_target_responder dut (
    .PCLK(PCLK), .PRESET(PRESET), .bus(bus_if),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .busy(busy), .rx_valid(rx_valid), .rx_ptr(rx_ptr), .rx_data(rx_data),
    .nack_seen(nack_seen), .state_dbg(state_dbg), .ptr_dbg(ptr_dbg)
  );

  always #5 PCLK = ~PCLK;

  int n_total = 0;
  int n_pass = 0;
  int rx_cnt = 0;
  int nack_cnt = 0;
  logic [PTR_W+7:0] exp_q[$];
  logic [7:0] exp_rd_q[$];

  // Write scoreboard: every stored byte must match the next expected {ptr, data}.
  always @(negedge PCLK) begin
    if (rx_valid === 1'b1) begin
      logic [PTR_W+7:0] e;
      rx_cnt++;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL rx_unexpected: got ptr %0h data %0h, required no write", rx_ptr, rx_data);
      end else begin
        e = exp_q.pop_front();
        if ({rx_ptr, rx_data} !== e)
          $display("FAIL rx_write: got ptr %0h data %0h, required ptr %0h data %0h",
                   rx_ptr, rx_data, e[PTR_W+7:8], e[7:0]);
        else n_pass++;
      end
    end
    if (nack_seen === 1'b1) nack_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic cfg_write(input logic [PTR_W-1:0] a, input logic [7:0] d);
    cfg_addr = a; cfg_wdata = d; cfg_we = 1'b1;
    wait_clk(1);
    cfg_we = 1'b0;
    wait_clk(1);
  endtask

  task automatic i2c_start;
    bus_if.sda_i = 1'b1; wait_clk(4);
    bus_if.scl_i = 1'b1; wait_clk(8);
    bus_if.sda_i = 1'b0; wait_clk(8);
    bus_if.scl_i = 1'b0; wait_clk(2);
  endtask

  task automatic i2c_stop;
    bus_if.sda_i = 1'b0; wait_clk(4);
    bus_if.scl_i = 1'b1; wait_clk(8);
    bus_if.sda_i = 1'b1; wait_clk(8);
  endtask

  // Called with SCL low; samples the target's SDA just before the rising edge.
  task automatic clock_bit(input logic b, output logic r);
    bus_if.sda_i = b; wait_clk(6);
    r = bus_if.sda_o;
    bus_if.scl_i = 1'b1; wait_clk(8);
    bus_if.scl_i = 1'b0; wait_clk(2);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], r);
    clock_bit(1'b1, r);
    acked = (r === 1'b0);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, r);
      d[i] = r;
    end
    clock_bit(~ack, r);
  endtask

  task automatic set_ptr(input logic [7:0] p, output int acks);
    logic a;
    acks = 0;
    i2c_start;
    write_byte(8'h56, a); acks += int'(a);
    write_byte(p, a);     acks += int'(a);
  endtask

  task automatic test_reset;
    PRESET = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    bus_if.scl_i = 1'b1; bus_if.sda_i = 1'b1;
    wait_clk(4);
    PRESET = 1'b0;
    wait_clk(2);
    n_total++; if (bus_if.sda_o !== 1'b1) $display("FAIL rst_sda: got %b required 1", bus_if.sda_o); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy); else n_pass++;
    n_total++; if (rx_valid !== 1'b0) $display("FAIL rst_rx_valid: got %b required 0", rx_valid); else n_pass++;
    n_total++; if (nack_seen !== 1'b0) $display("FAIL rst_nack: got %b required 0", nack_seen); else n_pass++;
    n_total++; if ({rx_ptr, rx_data} !== '0) $display("FAIL rst_rx: got %h required 0", {rx_ptr, rx_data}); else n_pass++;
    n_total++; if (state_dbg !== S_IDLE) $display("FAIL rst_state: got %0d required %0d", state_dbg, S_IDLE); else n_pass++;
    n_total++; if (ptr_dbg !== '0) $display("FAIL rst_ptr: got %0d required 0", ptr_dbg); else n_pass++;
  endtask

  task automatic test_read_after_ptr;
    logic a; logic [7:0] d, e; int acks, n0;
    cfg_write(4'd3, 8'hA5);
    cfg_write(4'd4, 8'h3C);
    n0 = nack_cnt;
    set_ptr(8'h03, acks);
    n_total++; if (acks !== 2) $display("FAIL t1_wr_acks: got %0d required 2", acks); else n_pass++;
    n_total++; if (ptr_dbg !== 4'd3) $display("FAIL t1_ptr_load: got %0d required 3", ptr_dbg); else n_pass++;
    i2c_start;
    write_byte(8'h57, a);
    n_total++; if (a !== 1'b1) $display("FAIL t1_rd_addr_ack: got %b required 1", a); else n_pass++;
    exp_rd_q.push_back(8'hA5);
    exp_rd_q.push_back(8'h3C);
    read_byte(1'b1, d); e = exp_rd_q.pop_front();
    n_total++; if (d !== e) $display("FAIL t1_byte0: got %h required %h", d, e); else n_pass++;
    read_byte(1'b0, d); e = exp_rd_q.pop_front();
    n_total++; if (d !== e) $display("FAIL t1_byte1: got %h required %h", d, e); else n_pass++;
    i2c_stop;
    n_total++; if (nack_cnt - n0 !== 1) $display("FAIL t1_nack_count: got %0d required 1", nack_cnt - n0); else n_pass++;
    n_total++; if (ptr_dbg !== 4'd5) $display("FAIL t1_ptr_after: got %0d required 5", ptr_dbg); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL t1_busy_after_stop: got %b required 0", busy); else n_pass++;
  endtask

  task automatic test_write_wrap;
    logic a; int acks, n0;
    logic [7:0] data [3] = '{8'h11, 8'h22, 8'h33};
    logic [PTR_W-1:0] ptrs [3] = '{4'd14, 4'd15, 4'd0};
    n0 = rx_cnt;
    set_ptr(8'h0E, acks);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({ptrs[i], data[i]});
      write_byte(data[i], a);
      acks += int'(a);
    end
    i2c_stop;
    n_total++; if (acks !== 5) $display("FAIL t2_ack_pulses: got %0d required 5", acks); else n_pass++;
    n_total++; if (rx_cnt - n0 !== 3) $display("FAIL t2_rx_count: got %0d required 3", rx_cnt - n0); else n_pass++;
    n_total++; if (ptr_dbg !== 4'd1) $display("FAIL t2_ptr_wrap: got %0d required 1", ptr_dbg); else n_pass++;
  endtask

  task automatic test_addr_nack;
    logic a; int n0;
    n0 = rx_cnt;
    i2c_start;
    write_byte(8'h58, a);
    n_total++; if (a !== 1'b0) $display("FAIL t3_addr_nack: got ack %b required 0", a); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL t3_busy: got %b required 1", busy); else n_pass++;
    n_total++; if (state_dbg !== S_WAIT_STOP) $display("FAIL t3_state: got %0d required %0d", state_dbg, S_WAIT_STOP); else n_pass++;
    write_byte(8'h00, a);
    n_total++; if (a !== 1'b0) $display("FAIL t3_ignored_byte: got ack %b required 0", a); else n_pass++;
    i2c_stop;
    n_total++; if (busy !== 1'b0) $display("FAIL t3_busy_stop: got %b required 0", busy); else n_pass++;
    n_total++; if (rx_cnt !== n0) $display("FAIL t3_no_rx: got %0d required %0d", rx_cnt, n0); else n_pass++;
  endtask

  task automatic test_stop_mid_write;
    logic a, r; logic [7:0] d, e; int acks, n0;
    cfg_write(4'd5, 8'h77);
    n0 = rx_cnt;
    set_ptr(8'h05, acks);
    for (int i = 0; i < 4; i++) clock_bit(1'(i[0]), r);
    i2c_stop;
    n_total++; if (state_dbg !== S_IDLE) $display("FAIL t4_state: got %0d required %0d", state_dbg, S_IDLE); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL t4_busy: got %b required 0", busy); else n_pass++;
    n_total++; if (rx_cnt !== n0) $display("FAIL t4_no_rx: got %0d required %0d", rx_cnt, n0); else n_pass++;
    set_ptr(8'h05, acks);
    i2c_start;
    write_byte(8'h57, a);
    exp_rd_q.push_back(8'h77);
    read_byte(1'b0, d); e = exp_rd_q.pop_front();
    i2c_stop;
    n_total++; if (d !== e) $display("FAIL t4_reg_kept: got %h required %h", d, e); else n_pass++;
  endtask

  task automatic test_reset_mid_ack;
    logic a, r; logic [7:0] d, e; logic [7:0] addr_b; int acks;
    addr_b = 8'h56;
    i2c_start;
    for (int i = 7; i >= 0; i--) clock_bit(addr_b[i], r);
    wait_clk(6);
    n_total++; if (bus_if.sda_o !== 1'b0) $display("FAIL t5_ack_low: got %b required 0", bus_if.sda_o); else n_pass++;
    n_total++; if (state_dbg !== S_ADDR_ACK) $display("FAIL t5_state_ack: got %0d required %0d", state_dbg, S_ADDR_ACK); else n_pass++;
    PRESET = 1'b1;
    wait_clk(1);
    n_total++; if (bus_if.sda_o !== 1'b1) $display("FAIL t5_sda_release: got %b required 1", bus_if.sda_o); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL t5_busy: got %b required 0", busy); else n_pass++;
    PRESET = 1'b0;
    bus_if.sda_i = 1'b1; wait_clk(4);
    bus_if.scl_i = 1'b1; wait_clk(8);
    set_ptr(8'h00, acks);
    i2c_start;
    write_byte(8'h57, a);
    for (int i = 0; i < 16; i++) begin
      exp_rd_q.push_back(8'h00);
      read_byte(i != 15, d); e = exp_rd_q.pop_front();
      n_total++; if (d !== e) $display("FAIL t5_reg_clear[%0d]: got %h required %h", i, d, e); else n_pass++;
    end
    i2c_stop;
  endtask

  task automatic test_cfg_while_busy;
    logic a; logic [7:0] d, e; int acks;
    set_ptr(8'h02, acks);
    cfg_write(4'd2, 8'hFF);
    i2c_start;
    write_byte(8'h57, a);
    exp_rd_q.push_back(8'h00);
    read_byte(1'b0, d); e = exp_rd_q.pop_front();
    i2c_stop;
    n_total++; if (d !== e) $display("FAIL t6_cfg_dropped: got %h required %h", d, e); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic a; logic [7:0] d, e; int acks;
    logic [7:0] model [16];
    logic [PTR_W-1:0] p;
    set_ptr(8'h0E, acks);
    for (int i = 0; i < 4; i++) begin
      p = 4'(14 + i);
      model[p] = 8'($urandom_range(0, 255));
      exp_q.push_back({p, model[p]});
      write_byte(model[p], a);
    end
    set_ptr(8'h0E, acks);
    i2c_start;
    write_byte(8'h57, a);
    for (int i = 0; i < 4; i++) begin
      p = 4'(14 + i);
      exp_rd_q.push_back(model[p]);
      read_byte(i != 3, d); e = exp_rd_q.pop_front();
      n_total++; if (d !== e) $display("FAIL b2b_read[%0d]: got %h required %h", i, d, e); else n_pass++;
    end
    i2c_stop;
    n_total++; if (ptr_dbg !== 4'd2) $display("FAIL b2b_ptr: got %0d required 2", ptr_dbg); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_read_after_ptr;
    test_write_wrap;
    test_addr_nack;
    test_stop_mid_write;
    test_reset_mid_ack;
    test_cfg_while_busy;
    test_back_to_back;
    wait_clk(4);
    n_total++;
    if (exp_q.size() != 0) $display("FAIL wr_queue_drained: got %0d left required 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
